// File: rtl/max_pool_2x2.sv
// rtl/max_pool_2x2.sv - 2x2 stride-2 max-pooling stage with packer valid codes
module max_pool_2x2 #(
    parameter int MAX_DIM = 16,
    parameter int DATA_W  = 8
) (
    input  logic              clk,
    input  logic              reset_b,
    input  logic              start,
    input  logic [4:0]        conv_dim,
    input  logic              conv_valid,
    input  logic [DATA_W-1:0] conv_data,
    input  logic              run_done,
    output logic [1:0]        valid_out,
    output logic [DATA_W-1:0] data_out,
    output logic              busy
);

    localparam int         CNT_W = $clog2(MAX_DIM);
    localparam int         LB_D  = MAX_DIM / 2;
    localparam int         LB_W  = $clog2(LB_D);
    localparam logic [4:0] MAX_N = 5'(MAX_DIM);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        EVEN_ROW = 2'd1,
        ODD_ROW  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [4:0]        neff;
    logic [4:0]        neff_in;
    logic [4:0]        neff_m1;
    logic [CNT_W-1:0]  col;
    logic [CNT_W-1:0]  row;
    logic [DATA_W-1:0] h_reg;
    logic [DATA_W-1:0] lbuf [LB_D];
    logic [LB_W-1:0]   lb_idx;
    logic [DATA_W-1:0] lb_rd;
    logic              pending;
    logic              last_d1;

    logic start_ok;
    logic accept;
    logic last_col;
    logic last_row;
    logic emit;
    logic map_end;
    logic pooled_on_out;
    logic release_mark;
    logic immediate_mark;

    function automatic logic [DATA_W-1:0] umax(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

    // Map side is floored to even and clamped to the line-buffer capacity.
    always_comb begin
        neff_in = conv_dim & ~5'd1;
        if (neff_in > MAX_N) begin
            neff_in = MAX_N;
        end
    end

    assign start_ok       = start && (state == IDLE) && (neff_in != 5'd0);
    assign accept         = conv_valid && (state != IDLE);
    assign neff_m1        = neff - 5'd1;
    assign last_col       = (5'(col) == neff_m1);
    assign last_row       = (5'(row) == neff_m1);
    assign lb_idx         = col[LB_W:1];
    assign lb_rd          = lbuf[lb_idx];
    assign emit           = accept && (state == ODD_ROW) && col[0];
    assign map_end        = emit && last_col && last_row;
    assign pooled_on_out  = (valid_out == 2'd1) || (valid_out == 2'd2);
    assign busy           = (state != IDLE);

    // A marker must never sit next to a pooled byte: it either goes out at once
    // from a quiet IDLE, or waits until two cycles after the map's last byte.
    assign release_mark   = last_d1 && (pending || run_done);
    assign immediate_mark = run_done && (state == IDLE) && !pooled_on_out && !last_d1;

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start_ok) begin
                    state_nxt = EVEN_ROW;
                end
            end
            EVEN_ROW: begin
                if (accept && last_col) begin
                    state_nxt = ODD_ROW;
                end
            end
            ODD_ROW: begin
                if (accept && last_col) begin
                    state_nxt = last_row ? IDLE : EVEN_ROW;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            neff  <= 5'd0;
            col   <= '0;
            row   <= '0;
            h_reg <= '0;
            for (int i = 0; i < LB_D; i++) begin
                lbuf[i] <= '0;
            end
        end else begin
            if (start_ok) begin
                neff <= neff_in;
                col  <= '0;
                row  <= '0;
            end
            if (accept) begin
                if (last_col) begin
                    col <= '0;
                    row <= (state == ODD_ROW && last_row) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
                if (state == EVEN_ROW) begin
                    if (!col[0]) begin
                        h_reg <= conv_data;
                    end else begin
                        lbuf[lb_idx] <= umax(h_reg, conv_data);
                    end
                end else if (!col[0]) begin
                    h_reg <= umax(lb_rd, conv_data);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            valid_out <= 2'd0;
            data_out  <= '0;
            pending   <= 1'b0;
            last_d1   <= 1'b0;
        end else begin
            valid_out <= 2'd0;
            data_out  <= '0;
            if (emit) begin
                valid_out <= (map_end && neff[1]) ? 2'd2 : 2'd1;
                data_out  <= umax(h_reg, conv_data);
            end else if (release_mark || immediate_mark) begin
                valid_out <= 2'd3;
            end
            if (release_mark) begin
                pending <= 1'b0;
            end else if (run_done && !immediate_mark) begin
                pending <= 1'b1;
            end
            // Outside a map, any pooled byte on the output is that map's last one.
            last_d1 <= (state == IDLE) && pooled_on_out;
        end
    end

endmodule

// File: tb/tb_max_pool_2x2.sv
// tb/tb_max_pool_2x2.sv - randomized self-checking bench for max_pool_2x2
module tb_max_pool_2x2;

    logic       clk = 1'b0;
    logic       reset_b = 1'b0;
    logic       start = 1'b0;
    logic [4:0] conv_dim = 5'd0;
    logic       conv_valid = 1'b0;
    logic [7:0] conv_data = 8'd0;
    logic       run_done = 1'b0;
    logic [1:0] valid_out;
    logic [7:0] data_out;
    logic       busy;

    max_pool_2x2 dut (
        .clk        (clk),
        .reset_b    (reset_b),
        .start      (start),
        .conv_dim   (conv_dim),
        .conv_valid (conv_valid),
        .conv_data  (conv_data),
        .run_done   (run_done),
        .valid_out  (valid_out),
        .data_out   (data_out),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    int obs_code[$], obs_data[$], obs_cyc[$], obs_busy[$];
    int exp_code[$], exp_data[$], exp_cyc[$], exp_busy[$];
    int last_out_cyc = -100;
    int px[256];

    always @(negedge clk) begin
        if (reset_b && valid_out != 2'd0) begin
            obs_code.push_back(int'(valid_out));
            obs_data.push_back(int'(data_out));
            obs_cyc.push_back(cyc);
            obs_busy.push_back(int'(busy));
            check("spacing", int'((cyc - last_out_cyc) >= 2), 1);
            last_out_cyc = cyc;
        end
    end

    task automatic push_exp(input int c, input int d, input int t, input int b);
        exp_code.push_back(c);
        exp_data.push_back(d);
        exp_cyc.push_back(t);
        exp_busy.push_back(b);
    endtask

    task automatic clear_queues();
        obs_code.delete(); obs_data.delete(); obs_cyc.delete(); obs_busy.delete();
        exp_code.delete(); exp_data.delete(); exp_cyc.delete(); exp_busy.delete();
    endtask

    task automatic compare(input string tag);
        int n;
        check($sformatf("%s count", tag), obs_code.size(), exp_code.size());
        n = (obs_code.size() < exp_code.size()) ? obs_code.size() : exp_code.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s[%0d] code", tag, i), obs_code[i], exp_code[i]);
            check($sformatf("%s[%0d] data", tag, i), obs_data[i], exp_data[i]);
            check($sformatf("%s[%0d] cycle", tag, i), obs_cyc[i], exp_cyc[i]);
            if (exp_busy[i] != 2) begin
                check($sformatf("%s[%0d] busy", tag, i), obs_busy[i], exp_busy[i]);
            end
        end
        clear_queues();
    endtask

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    // mode 0: ramp, 1: {0, 200..255}, 2: full random byte
    task automatic run_map(input int dim, input int gap_pct, input int rd_a, input int rd_b,
                           input bit rd_start, input int mode, input string tag);
        int n, p, cnt, s, t, last_t, r, c, i, j, gaps;
        n = (dim / 2) * 2;
        p = n / 2;
        last_t = 0;
        for (int k = 0; k < n * n; k++) begin
            case (mode)
                0:       px[k] = k % 256;
                1:       px[k] = ($urandom_range(1) == 0) ? 0 : int'($urandom_range(255, 200));
                default: px[k] = int'($urandom_range(255));
            endcase
        end
        @(posedge clk); #1;
        start = 1'b1;
        conv_dim = 5'(dim);
        run_done = rd_start;
        @(posedge clk); #1;
        s = cyc;
        start = 1'b0;
        run_done = 1'b0;
        check($sformatf("%s busy after start", tag), int'(busy), (n >= 2) ? 1 : 0);
        if (rd_start) push_exp(3, 0, s, 2);
        cnt = (n >= 2) ? n * n : 8;
        for (int k = 0; k < cnt; k++) begin
            gaps = 0;
            while (gaps < 3 && int'($urandom_range(99)) < gap_pct) begin
                conv_valid = 1'b0;
                conv_data = 8'($urandom);
                @(posedge clk); #1;
                gaps++;
            end
            conv_valid = 1'b1;
            conv_data = (n >= 2) ? 8'(px[k]) : 8'($urandom);
            run_done = (k == rd_a) || (k == rd_b);
            @(posedge clk); #1;
            conv_valid = 1'b0;
            run_done = 1'b0;
            t = cyc;
            if (n >= 2) begin
                r = k / n;
                c = k % n;
                if ((r % 2 == 1) && (c % 2 == 1)) begin
                    i = r / 2;
                    j = c / 2;
                    if (i == p - 1 && j == p - 1) begin
                        push_exp((p % 2 == 1) ? 2 : 1,
                                 max4(px[(r-1)*n + c-1], px[(r-1)*n + c], px[r*n + c-1], px[r*n + c]),
                                 t, 0);
                    end else begin
                        push_exp(1,
                                 max4(px[(r-1)*n + c-1], px[(r-1)*n + c], px[r*n + c-1], px[r*n + c]),
                                 t, 1);
                    end
                    last_t = t;
                end
            end else begin
                check($sformatf("%s busy idle", tag), int'(busy), 0);
            end
        end
        if (rd_a >= 0) push_exp(3, 0, last_t + 2, 2);
        repeat (6) @(posedge clk);
        #1;
        compare(tag);
    endtask

    initial begin
        int t;
        #3;
        check("reset valid_out", int'(valid_out), 0);
        check("reset data_out", int'(data_out), 0);
        check("reset busy", int'(busy), 0);
        repeat (3) @(posedge clk);
        #1;
        reset_b = 1'b1;
        repeat (2) @(posedge clk);

        run_map(4, 0, -1, -1, 1'b0, 0, "n4_ramp");
        run_map(6, 0, -1, -1, 1'b0, 0, "n6_ramp");
        for (int k = 0; k < 3; k++) begin
            run_map(4, 40, -1, -1, 1'b0, 1, $sformatf("n4_gaps%0d", k));
        end
        run_map(2, 0, 1, 2, 1'b0, 0, "n2_run_done");

        @(posedge clk); #1;
        run_done = 1'b1;
        t = cyc;
        @(posedge clk); #1;
        run_done = 1'b0;
        push_exp(3, 0, t + 1, 0);
        repeat (4) @(posedge clk);
        #1;
        compare("idle_run_done");

        run_map(4, 0, -1, -1, 1'b1, 2, "n4_start_rd");

        @(posedge clk); #1;
        start = 1'b1;
        conv_dim = 5'd6;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 7; k++) begin
            conv_valid = 1'b1;
            conv_data = 8'(k);
            @(posedge clk); #1;
        end
        conv_valid = 1'b0;
        check("busy mid-map", int'(busy), 1);
        #2;
        reset_b = 1'b0;
        #1;
        check("mid reset valid_out", int'(valid_out), 0);
        check("mid reset data_out", int'(data_out), 0);
        check("mid reset busy", int'(busy), 0);
        @(posedge clk); #1;
        reset_b = 1'b1;
        check("mid reset outputs seen", obs_code.size(), 0);
        clear_queues();
        run_map(4, 20, -1, -1, 1'b0, 2, "after_reset");

        run_map(1, 0, -1, -1, 1'b0, 2, "dim1");
        run_map(0, 0, -1, -1, 1'b0, 2, "dim0");
        run_map(5, 20, -1, -1, 1'b0, 2, "dim5");
        run_map(8, 25, 10, 11, 1'b0, 2, "n8_rd");
        run_map(16, 10, -1, -1, 1'b0, 2, "n16");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
